// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I-cache / D-cache memory arbiter.
//   state_t         : arbiter FSM encoding (idle / serving I / serving D)
//   ADDR_W_DEF      : default line-address width
//   LINE_W_DEF      : default memory line width
//   CLI_I / CLI_D   : client ids used for grant and last_grant
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERV_I = 2'd1,
        S_SERV_D = 2'd2
    } state_t;

    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin chooser.
//   i_req, d_req : pending requests from the I and D clients
//   last_grant   : client granted most recently (CLI_I / CLI_D)
//   grant_valid  : at least one request pending
//   grant_id     : chosen client; on a tie, the one not granted last
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = CLI_I;
        if (i_req && d_req)
            grant_id = (last_grant == CLI_D) ? CLI_I : CLI_D;
        else if (d_req)
            grant_id = CLI_D;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the instruction cache and data cache line requests and the
// single shared 128-bit memory port. One transaction is open at a time; the
// winning request is latched into the mem_* registers and completion
// (mem_ready / mem_rdata) is routed back only to the granted client.
//   clk, proc_reset                 : clock, synchronous active-high reset
//   i_mem_read / i_mem_addr         : I-cache line fetch request (read only)
//   i_mem_ready / i_mem_rdata       : I-cache completion pulse and line
//   d_mem_read / d_mem_write        : D-cache request (write wins if both)
//   d_mem_addr / d_mem_wdata        : D-cache line address and write line
//   d_mem_ready / d_mem_rdata       : D-cache completion pulse and line
//   mem_read / mem_write            : registered memory command
//   mem_addr / mem_wdata            : registered memory address / write line
//   mem_rdata / mem_ready           : memory read data and completion
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              i_mem_ready,
    output logic [LINE_W-1:0] i_mem_rdata,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic              d_mem_ready,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t state, state_nxt;
    logic   last_grant;
    logic   i_req, d_req;
    logic   grant_valid, grant_id;
    logic   grant;
    logic   done;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    arb_rr_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Requests are only looked at from idle; in service they are ignored.
    assign grant = (state == S_IDLE) && grant_valid;
    // mem_ready outside a service state is spurious and dropped.
    assign done  = (state != S_IDLE) && mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_valid)
                    state_nxt = (grant_id == CLI_D) ? S_SERV_D : S_SERV_I;
            end
            S_SERV_I, S_SERV_D: begin
                if (mem_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: completion goes straight through to the owner only.
    always_comb begin
        i_mem_ready = (state == S_SERV_I) && mem_ready;
        d_mem_ready = (state == S_SERV_D) && mem_ready;
        i_mem_rdata = i_mem_ready ? mem_rdata : '0;
        d_mem_rdata = d_mem_ready ? mem_rdata : '0;
    end

    // Latched memory command. Address/data keep their last values after
    // completion; only the command strobes clear.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            last_grant <= CLI_D;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (grant) begin
            last_grant <= grant_id;
            if (grant_id == CLI_D) begin
                mem_addr  <= d_mem_addr;
                mem_wdata <= d_mem_wdata;
                mem_read  <= ~d_mem_write;
                mem_write <= d_mem_write;
            end else begin
                mem_addr  <= i_mem_addr;
                mem_wdata <= '0;
                mem_read  <= 1'b1;
                mem_write <= 1'b0;
            end
        end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int LW = 128;

    localparam logic [LW-1:0] RA = {4{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] RB = {4{32'hCAFE_F00D}};
    localparam logic [LW-1:0] W1 = {4{32'h1111_1111}};
    localparam logic [LW-1:0] W2 = {4{32'h2222_3333}};
    localparam logic [LW-1:0] Z  = '0;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_addr;
    logic          i_mem_ready;
    logic [LW-1:0] i_mem_rdata;
    logic          d_mem_read, d_mem_write;
    logic [AW-1:0] d_mem_addr;
    logic [LW-1:0] d_mem_wdata;
    logic          d_mem_ready;
    logic [LW-1:0] d_mem_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .proc_reset  (proc_reset),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .d_mem_read  (d_mem_read),
        .d_mem_write (d_mem_write),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_ready (d_mem_ready),
        .d_mem_rdata (d_mem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct {
        logic          rst, ird;
        logic [AW-1:0] iaddr;
        logic          drd, dwr;
        logic [AW-1:0] daddr;
        logic [LW-1:0] dwdata;
        logic          mrdy;
        logic [LW-1:0] mrdata;
        logic          e_irdy;
        logic [LW-1:0] e_irdata;
        logic          e_drdy;
        logic [LW-1:0] e_drdata;
        logic          e_mrd, e_mwr;
        logic [AW-1:0] e_maddr;
        logic [LW-1:0] e_mwdata;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(
        input logic rst, input logic ird, input logic [AW-1:0] iaddr,
        input logic drd, input logic dwr, input logic [AW-1:0] daddr, input logic [LW-1:0] dwdata,
        input logic mrdy, input logic [LW-1:0] mrdata,
        input logic eir, input logic [LW-1:0] eird, input logic edr, input logic [LW-1:0] edrd,
        input logic emr, input logic emw, input logic [AW-1:0] ema, input logic [LW-1:0] emwd);
        vec_t v;
        v.rst = rst; v.ird = ird; v.iaddr = iaddr;
        v.drd = drd; v.dwr = dwr; v.daddr = daddr; v.dwdata = dwdata;
        v.mrdy = mrdy; v.mrdata = mrdata;
        v.e_irdy = eir; v.e_irdata = eird; v.e_drdy = edr; v.e_drdata = edrd;
        v.e_mrd = emr; v.e_mwr = emw; v.e_maddr = ema; v.e_mwdata = emwd;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mem_read = 0; i_mem_addr = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // cols: rst ird iaddr | drd dwr daddr dwdata | mrdy mrdata || irdy irdata drdy drdata | mrd mwr maddr mwdata
        vt[0]  = mk(1,0,28'h0,     0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'h0,  Z);
        vt[1]  = mk(0,1,28'h123,   0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'h0,  Z);
        vt[2]  = mk(0,1,28'h123,   0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  1,0,28'h123,Z);
        vt[3]  = mk(0,1,28'h123,   0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  1,0,28'h123,Z);
        vt[4]  = mk(0,1,28'h123,   0,0,28'h0, Z, 1,RA, 1,RA,0,Z,  1,0,28'h123,Z);
        vt[5]  = mk(0,0,28'h0,     0,0,28'h0, Z, 1,RB, 0,Z, 0,Z,  0,0,28'h123,Z);
        vt[6]  = mk(0,0,28'h0,     0,1,28'h40,W1,0,Z,  0,Z, 0,Z,  0,0,28'h123,Z);
        vt[7]  = mk(0,0,28'h0,     0,1,28'h41,W2,0,Z,  0,Z, 0,Z,  0,1,28'h40, W1);
        vt[8]  = mk(0,0,28'h0,     0,1,28'h41,W2,1,RB, 0,Z, 1,RB, 0,1,28'h40, W1);
        vt[9]  = mk(0,0,28'h0,     0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'h40, W1);
        vt[10] = mk(0,0,28'h0,     1,1,28'h77,W2,0,Z,  0,Z, 0,Z,  0,0,28'h40, W1);
        vt[11] = mk(0,0,28'h0,     1,1,28'h77,W2,0,Z,  0,Z, 0,Z,  0,1,28'h77, W2);
        vt[12] = mk(0,0,28'h0,     0,0,28'h0, Z, 1,RA, 0,Z, 1,RA, 0,1,28'h77, W2);
        vt[13] = mk(0,0,28'h0,     0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'h77, W2);
        vt[14] = mk(0,0,28'h0,     1,0,28'h55,Z, 0,Z,  0,Z, 0,Z,  0,0,28'h77, W2);
        vt[15] = mk(0,1,28'hAA,    1,0,28'h55,Z, 0,Z,  0,Z, 0,Z,  1,0,28'h55, Z);
        vt[16] = mk(0,1,28'hAA,    0,0,28'h0, Z, 1,RB, 0,Z, 1,RB, 1,0,28'h55, Z);
        vt[17] = mk(0,1,28'hAA,    0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'h55, Z);
        vt[18] = mk(0,1,28'hAA,    0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  1,0,28'hAA, Z);
        vt[19] = mk(0,0,28'h0,     0,0,28'h0, Z, 1,RA, 1,RA,0,Z,  1,0,28'hAA, Z);
        vt[20] = mk(0,0,28'h0,     0,0,28'h0, Z, 0,Z,  0,Z, 0,Z,  0,0,28'hAA, Z);

        idle_inputs();
        proc_reset = 1;
        cyc(); cyc();

        // Table: inputs applied just after the edge, outputs sampled on negedge.
        for (int k = 0; k < 21; k++) begin
            logic [415:0] act, exp;
            cyc();
            proc_reset  = vt[k].rst;
            i_mem_read  = vt[k].ird;  i_mem_addr = vt[k].iaddr;
            d_mem_read  = vt[k].drd;  d_mem_write = vt[k].dwr;
            d_mem_addr  = vt[k].daddr; d_mem_wdata = vt[k].dwdata;
            mem_ready   = vt[k].mrdy; mem_rdata = vt[k].mrdata;
            @(negedge clk);
            act = {i_mem_ready, i_mem_rdata, d_mem_ready, d_mem_rdata,
                   mem_read, mem_write, mem_addr, mem_wdata};
            exp = {vt[k].e_irdy, vt[k].e_irdata, vt[k].e_drdy, vt[k].e_drdata,
                   vt[k].e_mrd, vt[k].e_mwr, vt[k].e_maddr, vt[k].e_mwdata};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL vec%0d: got %0h expected %0h", k, act, exp);
            end
        end

        // Contention right after reset: both held, grants go I, D, I.
        cyc(); idle_inputs(); proc_reset = 1;
        cyc(); proc_reset = 0;
        i_mem_read = 1; i_mem_addr = 28'h100;
        d_mem_read = 1; d_mem_addr = 28'h200;
        cyc();
        @(negedge clk);
        chk("rr1_addr", LW'(mem_addr), LW'(28'h100));
        chk("rr1_rd",   LW'(mem_read), LW'(1));
        cyc(); mem_ready = 1; mem_rdata = RA;
        @(negedge clk);
        chk("rr1_irdy", LW'({i_mem_ready, d_mem_ready}), LW'(2'b10));
        chk("rr1_irdata", i_mem_rdata, RA);
        cyc(); mem_ready = 0; mem_rdata = '0;   // idle, both still requesting
        cyc();
        @(negedge clk);
        chk("rr2_addr", LW'(mem_addr), LW'(28'h200));
        cyc(); mem_ready = 1; mem_rdata = RB;
        @(negedge clk);
        chk("rr2_drdy", LW'({i_mem_ready, d_mem_ready}), LW'(2'b01));
        chk("rr2_drdata", d_mem_rdata, RB);
        chk("rr2_irdata", i_mem_rdata, Z);
        cyc(); mem_ready = 0; mem_rdata = '0;
        cyc();
        @(negedge clk);
        chk("rr3_addr", LW'(mem_addr), LW'(28'h100));
        cyc(); mem_ready = 1; mem_rdata = RA;
        cyc(); mem_ready = 0; idle_inputs();
        cyc();
        @(negedge clk);
        chk("rr_end_cmd", LW'({mem_read, mem_write}), LW'(2'b00));

        // Address change during service has no effect.
        i_mem_read = 1; i_mem_addr = 28'h123;
        cyc(); i_mem_addr = 28'h999;
        @(negedge clk);
        chk("hold_addr0", LW'(mem_addr), LW'(28'h123));
        cyc();
        @(negedge clk);
        chk("hold_addr1", LW'(mem_addr), LW'(28'h123));
        cyc(); mem_ready = 1; mem_rdata = RB;
        @(negedge clk);
        chk("hold_irdy", LW'(i_mem_ready), LW'(1));
        cyc(); idle_inputs();
        @(negedge clk);
        chk("hold_done", LW'({mem_read, mem_addr}), LW'({1'b0, 28'h123}));

        // Reset while serving a D write aborts it; later mem_ready ignored.
        d_mem_write = 1; d_mem_addr = 28'h40; d_mem_wdata = W1;
        cyc();
        @(negedge clk);
        chk("rst_pre_wr", LW'(mem_write), LW'(1));
        cyc(); proc_reset = 1; d_mem_write = 0;
        cyc(); proc_reset = 0;
        @(negedge clk);
        chk("rst_cmd",   LW'({mem_read, mem_write, mem_addr}), LW'(0));
        chk("rst_wdata", mem_wdata, Z);
        cyc(); mem_ready = 1; mem_rdata = RA;
        @(negedge clk);
        chk("rst_late_rdy", LW'({i_mem_ready, d_mem_ready}), LW'(0));
        chk("rst_late_rdata", d_mem_rdata, Z);
        cyc(); mem_ready = 0;
        @(negedge clk);
        chk("rst_still_idle", LW'({mem_read, mem_write}), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
